// File: rtl/univ_shift_reg.sv
// Universal shift register with a shift-by-N sequencer.
// Single-step mode applies one operation per enabled clock: hold, load,
// logical or arithmetic shift, rotate or clear. A start/busy/done handshake
// repeats a shift or rotate up to WIDTH times. Shift counts above WIDTH are
// treated as WIDTH.
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   en             single-step enable, honoured only while idle
//   mode[2:0]      operation select
//   d[WIDTH-1:0]   parallel load data
//   sin_l          serial input entering at the MSB on right shifts
//   sin_r          serial input entering at the LSB on left shifts
//   start          launch a multi-step operation
//   shamt[CW-1:0]  step count for start
//   q[WIDTH-1:0]   register contents
//   sout_l         q[WIDTH-1]
//   sout_r         q[0]
//   busy           high while the sequencer is stepping
//   done           one-cycle completion pulse
module univ_shift_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CW-1:0]    shamt,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ASR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ROR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        op_r;
    logic [2:0]        op_nxt;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [WIDTH-1:0]  q_nxt;
    logic [CW-1:0]     shamt_clamped;
    logic              start_short;

    // One application of an operation to the current register value.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             sl,
        input logic             sr,
        input logic [WIDTH-1:0] ld
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (op)
            M_HOLD:  r = cur;
            M_LOAD:  r = ld;
            M_SHL:   r = {cur[WIDTH-2:0], sr};
            M_SHR:   r = {sl, cur[WIDTH-1:1]};
            M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
            M_CLR:   r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Counts above WIDTH saturate; a rotate by WIDTH is already a full turn.
    assign shamt_clamped = (shamt > CW'(WIDTH)) ? CW'(WIDTH) : shamt;

    // Starts that finish on the launch edge: zero count, hold, load or clear.
    assign start_short = (shamt == '0) || (mode == M_HOLD) ||
                         (mode == M_LOAD) || (mode == M_CLR);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = start_short ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (count <= CW'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values for q, the latched operation and the step count.
    always_comb begin
        q_nxt     = q;
        op_nxt    = op_r;
        count_nxt = count;
        case (state)
            S_IDLE: begin
                if (start) begin
                    op_nxt    = mode;
                    count_nxt = shamt_clamped;
                    // Load and clear take effect on the launch edge; shifts do not.
                    if (mode == M_LOAD || mode == M_CLR) begin
                        q_nxt = apply_op(mode, q, sin_l, sin_r, d);
                    end
                end else if (en) begin
                    q_nxt = apply_op(mode, q, sin_l, sin_r, d);
                end
            end
            S_RUN: begin
                q_nxt     = apply_op(op_r, q, sin_l, sin_r, d);
                count_nxt = count - CW'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= RESET_VAL;
            op_r  <= M_HOLD;
            count <= '0;
        end else begin
            q     <= q_nxt;
            op_r  <= op_nxt;
            count <= count_nxt;
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg (WIDTH=8, RESET_VAL=8'h5A).
module tb_univ_shift_reg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic             start;
    logic [CW-1:0]    shamt;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    univ_shift_reg #(
        .WIDTH    (WIDTH),
        .RESET_VAL(8'h5A)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .start (start),
        .shamt (shamt),
        .q     (q),
        .sout_l(sout_l),
        .sout_r(sout_r),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        en = 1'b1; mode = 3'b001; d = v;
        step();
        en = 1'b0;
    endtask

    // Run the sequencer from just after the launch edge until done; returns busy cycles.
    task automatic run_to_done(input string tag, output int nbusy);
        int guard;
        nbusy = 0;
        guard = 0;
        while (!done && guard < 40) begin
            if (busy) nbusy++;
            chk({tag, "_overlap"}, 32'(busy & done), 32'd0);
            en   = $urandom_range(0, 1);
            mode = 3'($urandom_range(0, 7));
            d    = 8'($urandom);
            step();
            guard++;
        end
        en = 1'b0; mode = 3'b000;
        chk({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    initial begin
        int nb;
        int ndone;
        reset = 1'b1; en = 1'b0; mode = 3'b000; d = '0;
        sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; shamt = '0;

        // 1: reset value, then async reset between edges
        #12;
        chk("rst_q", 32'(q), 32'h5A);
        reset = 1'b0;
        step();
        load(8'h11);
        chk("pre_rst_q", 32'(q), 32'h11);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_q", 32'(q), 32'h5A);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        @(negedge clk); reset = 1'b0;
        step();
        chk("hold_after_rst", 32'(q), 32'h5A);

        // 2: load, hold, clear
        load(8'hAA);
        chk("load_aa", 32'(q), 32'hAA);
        en = 1'b0; d = 8'hFF;
        step();
        chk("en0_hold", 32'(q), 32'hAA);
        en = 1'b1; mode = 3'b111;
        step();
        en = 1'b0;
        chk("clear", 32'(q), 32'h00);

        // 3: single-step shift/rotate ops
        load(8'h81);
        en = 1'b1; mode = 3'b101; step(); en = 1'b0;
        chk("rol", 32'(q), 32'h03);
        load(8'h81);
        en = 1'b1; mode = 3'b100; step(); en = 1'b0;
        chk("asr", 32'(q), 32'hC0);
        chk("asr_sout_l", 32'(sout_l), 32'd1);
        chk("asr_sout_r", 32'(sout_r), 32'd0);
        load(8'h81);
        en = 1'b1; mode = 3'b011; sin_l = 1'b0; step(); en = 1'b0;
        chk("lsr", 32'(q), 32'h40);
        load(8'h81);
        en = 1'b1; mode = 3'b110; step(); en = 1'b0;
        chk("ror", 32'(q), 32'hC0);
        load(8'h81);
        en = 1'b1; mode = 3'b010; sin_r = 1'b0; step(); en = 1'b0;
        chk("shl", 32'(q), 32'h02);

        // 4: shift-left by 3 with sin_r=1; en/mode churn during busy
        load(8'h01);
        sin_r = 1'b1;
        start = 1'b1; mode = 3'b010; shamt = 4'd3;
        step();
        start = 1'b0;
        chk("seq_start_q", 32'(q), 32'h01);
        chk("seq_start_busy", 32'(busy), 32'd1);
        run_to_done("seq3", nb);
        chk("seq3_busy_cycles", 32'(nb), 32'd3);
        chk("seq3_q", 32'(q), 32'h0F);
        chk("seq3_busy_at_done", 32'(busy), 32'd0);
        step();
        chk("seq3_done_1cyc", 32'(done), 32'd0);
        chk("seq3_q_after", 32'(q), 32'h0F);

        // 5a: zero count finishes immediately
        start = 1'b1; mode = 3'b010; shamt = 4'd0;
        step();
        start = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_q", 32'(q), 32'h0F);
        step();
        chk("zero_done_clr", 32'(done), 32'd0);

        // 5b: start held into RUN is ignored; exactly one done
        sin_r = 1'b0;
        start = 1'b1; mode = 3'b010; shamt = 4'd2;
        step();
        step();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            step();
        end
        chk("blocked_start_dones", 32'(ndone), 32'd1);
        chk("blocked_start_q", 32'(q), 32'h3C);

        // 6a: rotate by WIDTH and by an over-range count
        start = 1'b1; mode = 3'b101; shamt = 4'd8;
        step();
        start = 1'b0;
        run_to_done("rol8", nb);
        chk("rol8_busy_cycles", 32'(nb), 32'd8);
        chk("rol8_q", 32'(q), 32'h3C);
        step();
        start = 1'b1; mode = 3'b101; shamt = 4'd15;
        step();
        start = 1'b0;
        run_to_done("rol15", nb);
        chk("rol15_clamped_cycles", 32'(nb), 32'd8);
        chk("rol15_q", 32'(q), 32'h3C);
        step();
        sin_l = 1'b1;
        start = 1'b1; mode = 3'b011; shamt = 4'd9;
        step();
        start = 1'b0;
        run_to_done("lsr9", nb);
        chk("lsr9_q", 32'(q), 32'hFF);
        step();
        sin_l = 1'b0;

        // 6b: abort a rotate after two shifts
        load(8'h3C);
        start = 1'b1; mode = 3'b101; shamt = 4'd8;
        step();
        start = 1'b0;
        step();
        step();
        chk("abort_mid_q", 32'(q), 32'hF0);
        #3 reset = 1'b1;
        #1;
        chk("abort_q", 32'(q), 32'h5A);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk); reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done || busy) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_q_hold", 32'(q), 32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register, the next generation of the team's 8-bit enable register. Adds parallel load, logical/arithmetic shift, rotate, clear and serial in/out. Also runs a multi-cycle shift-by-N sequencer with a start/busy/done handshake. Used as a datapath register and a serialiser front-end.

Parameters:
WIDTH, 8, data width in bits (>=2)
RESET_VAL, '0 (WIDTH bits), value loaded into q on reset
CW, $clog2(WIDTH+1), width of shamt (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  single-step enable (idle only)
mode  input  3  operation select (see Behaviour)
d  input  WIDTH  parallel load data
sin_l  input  1  serial in at MSB side (right shifts)
sin_r  input  1  serial in at LSB side (left shifts)
start  input  1  launch multi-step operation
shamt  input  CW  step count for start, 0..WIDTH
q  output  WIDTH  register contents
sout_l  output  1  q[WIDTH-1], combinational from q
sout_r  output  1  q[0], combinational from q
busy  output  1  high while sequencer is in RUN
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): q=RESET_VAL, state=IDLE, busy=0, done=0, internal count=0. Outputs change immediately, not at the next edge.
- mode encoding:
  - 000 hold
  - 001 load d
  - 010 shift left: q<={q[W-2:0],sin_r}
  - 011 logical shift right: q<={sin_l,q[W-1:1]}
  - 100 arithmetic shift right: q<={q[W-1],q[W-1:1]}
  - 101 rotate left
  - 110 rotate right
  - 111 clear to 0 (not RESET_VAL)
- Single-step (state IDLE, start=0): en=1 applies mode at the clock edge; en=0 holds q. Latency is 1 cycle.
- FSM states are IDLE, RUN, DONE.
- IDLE, start=1 at edge:
  - Capture mode into op_r and shamt into count; q unchanged on this edge.
  - If shamt=0, or op_r is 000, 001 or 111: go to DONE. For 001/111 the load/clear is applied on this edge.
  - Otherwise go to RUN.
- RUN:
  - busy=1.
  - Each edge applies op_r once and decrements count.
  - sin_l/sin_r are sampled fresh on each shift edge.
  - The edge where count goes 1->0 moves to DONE.
- DONE: done=1, busy=0, lasts exactly one cycle, then IDLE. A new start is accepted only after the return to IDLE.
- Latency: for shamt=k>0 with a shift/rotate op, busy is high for k cycles after the start edge. The final q is visible in the cycle done=1, i.e. k+1 edges after start is sampled.
- shamt>WIDTH: clamp to WIDTH. Rotates by WIDTH return the original q; shifts by WIDTH fill entirely with serial/sign bits.
- Simultaneous events:
  - start and en both high in IDLE: start wins, en ignored.
  - start, en, mode, d while in RUN/DONE: ignored.
  - reset overrides everything.
- Reset mid-RUN: q=RESET_VAL, busy=0. No done pulse for the aborted operation.
- done and busy are never high in the same cycle.

Test Plan:
1. WIDTH=8, RESET_VAL=8'h5A. Assert reset between clock edges -> q=8'h5A immediately, busy=0, done=0. Release -> q holds 8'h5A with en=0.
2. en=1, mode=001, d=8'hAA -> q=8'hAA after one edge. Then en=0, d=8'hFF -> q stays 8'hAA. Then en=1, mode=111 -> q=8'h00.
3. Single-step ops with q=8'h81:
   - mode=101 -> q=8'h03.
   - Reload 8'h81, mode=100 -> q=8'hC0; sout_l=1, sout_r=0.
   - Reload 8'h81, mode=011, sin_l=0 -> q=8'h40.
4. Shift sequence: q=8'h01, start with mode=010, shamt=3, sin_r=1 held.
   - busy=1 for exactly 3 cycles, then done=1 for one cycle with q=8'h0F.
   - Toggling en/mode during busy has no effect.
5. Zero count and blocked start:
   - start with shamt=0 -> done on the next cycle, busy never high, q unchanged.
   - start asserted during RUN -> ignored; only one done pulse.
6. Abort and rotate-by-WIDTH:
   - start mode=101, shamt=8 on q=8'h3C -> done with q=8'h3C.
   - Repeat, asserting reset after 2 shifts -> q=8'h5A immediately, busy=0, no done pulse.
